// File: rtl/if_id_pipe.sv
// IF/ID pipeline register: replays held instructions across stalls and
// injects FLUSH_DEPTH bubbles per redirect. Define IF_ID_PERF_EN for perf counters.
module if_id_pipe #(
   parameter int               XLEN        = 32,
   parameter int               ILEN        = 32,
   parameter int               FLUSH_DEPTH = 2,
   parameter logic [ILEN-1:0]  NOP_INSTR   = ILEN'(32'h0000_0013),
   parameter logic [XLEN-1:0]  RESET_PC    = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_i,
   input  logic [ILEN-1:0] instr_i,
   input  logic            stall,
   input  logic            flush,
   output logic [XLEN-1:0] pc_ID,
   output logic [ILEN-1:0] instr_ID,
   output logic            valid_ID,
   output logic [31:0]     perf_bubble_cnt,
   output logic [31:0]     perf_stall_cnt
);

   logic            stall_q;
   logic            valid_q;
   logic [ILEN-1:0] hold_q;
   logic [2:0]      kill_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_ID    <= RESET_PC;
         stall_q  <= 1'b0;
         hold_q   <= NOP_INSTR;
         valid_q  <= 1'b0;
         kill_cnt <= 3'd1;
      end else begin
         if (!stall) pc_ID <= pc_i;
         stall_q <= stall;
         // Capture what ID shows now so a multi-cycle stall replays it verbatim.
         hold_q  <= instr_ID;
         valid_q <= valid_ID;
         if (flush)                kill_cnt <= 3'(FLUSH_DEPTH - 1);
         else if (kill_cnt != 3'd0) kill_cnt <= kill_cnt - 3'd1;
      end
   end

   always_comb begin
      instr_ID = instr_i;
      valid_ID = 1'b1;
      if (flush || kill_cnt != 3'd0) begin
         instr_ID = NOP_INSTR;
         valid_ID = 1'b0;
      end else if (stall_q) begin
         instr_ID = hold_q;
         valid_ID = valid_q;
      end
   end

`ifdef IF_ID_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_bubble_cnt <= '0;
         perf_stall_cnt  <= '0;
      end else begin
         if (!valid_ID) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
         if (stall)     perf_stall_cnt  <= perf_stall_cnt + 32'd1;
      end
   end
`else
   assign perf_bubble_cnt = '0;
   assign perf_stall_cnt  = '0;
`endif

endmodule

// File: doc/if_id_pipe.md
Name: if_id_pipe

Overview:
Parametrised IF/ID pipeline register for the in-order RISC-V core; successor to the fixed 32-bit, one-cycle-stall, two-bubble IF/ID stage.
- Holds PC and instruction for the decode stage.
- Replays the held instruction across stalls of any length.
- Injects a configurable number of NOP bubbles after a redirect (branch taken / jump).
- Flags each ID slot valid or bubble.
- Sits between the synchronous instruction memory (data returns one cycle after the address) and decode.

Parameters:
XLEN, 32, width of PC path.
ILEN, 32, instruction width.
FLUSH_DEPTH, 2, bubbles injected per redirect; legal 1..7.
NOP_INSTR, 32'h0000_0013, encoding driven on bubbles (addi x0,x0,0).
RESET_PC, 0, reset value of pc_ID.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
pc_i  input  XLEN  PC of the fetch issued this cycle
instr_i  input  ILEN  instruction-memory read data, for the fetch issued last cycle
stall  input  1  hazard-unit hold; ID contents must be held in the next cycle
flush  input  1  redirect from EX (branch taken/jump); kills the current and following fetched slots
pc_ID  output  XLEN  decode-stage PC
instr_ID  output  ILEN  decode-stage instruction
valid_ID  output  1  1 = instr_ID is a real instruction, 0 = injected bubble
perf_bubble_cnt  output  32  bubble counter (optional feature)
perf_stall_cnt  output  32  stall counter (optional feature)

Behaviour:
- Clock and reset: single clock clk; rst asynchronous, active-high, clears every flop immediately.
- Reset values:
  - pc_ID = RESET_PC; stall_q = 0; hold_q = NOP_INSTR.
  - kill_cnt = 1, so the first cycle after reset release is a bubble.
  - While rst is high: instr_ID = NOP_INSTR, valid_ID = 0, perf counters = 0.
- pc_ID:
  - Registered; on each edge loads pc_i when stall = 0, otherwise holds.
  - Latency 1 cycle.
  - flush does not gate pc_ID; the slot's instruction is killed instead.
- stall_q: registered copy of stall.
- hold_q: loads the current instr_ID on every edge, so it holds stable for the whole of a multi-cycle stall.
- kill_cnt (3 bits):
  - If flush, load FLUSH_DEPTH-1.
  - Else if kill_cnt != 0, decrement.
  - Else hold at 0.
  - flush while kill_cnt != 0 reloads (extends), never accumulates.
- instr_ID select, combinational, in priority order:
  1. flush = 1 or kill_cnt != 0: NOP_INSTR, valid_ID = 0.
  2. stall_q = 1: hold_q (replay); valid_ID = previous valid_ID, kept in a valid_q flop loaded alongside hold_q.
  3. Otherwise: instr_i, valid_ID = 1.
- Redirect timing: a flush seen in cycle t yields bubbles in cycles t .. t+FLUSH_DEPTH-1. For FLUSH_DEPTH=2 this matches the legacy 2-bubble penalty.
- Simultaneous stall and flush: flush wins for instr_ID.
  - pc_ID still holds, since stall gates it.
  - The replay in the next cycle returns NOP with valid 0, because hold_q captured the bubble.
- A stall of N consecutive cycles gives N+1 cycles of the identical pc_ID/instr_ID pair. The instr_i data present during the stall is discarded; the upstream PC is held, so the same fetch is re-issued.
- Reset mid-stall or mid-flush: all state is lost; behaviour restarts from the reset values.

Optional Feature:
IF_ID_PERF_EN
- Defined:
  - perf_bubble_cnt increments on each clk edge where valid_ID = 0 and rst = 0.
  - perf_stall_cnt increments on each edge where stall = 1.
  - Both are 32-bit, wrap at 2^32-1 to 0, and reset to 0.
- Not defined: both outputs are tied to 0, no counter flops are inferred, and ports remain present.

Test Plan:
- Reset release, then instr_i=0x00500093 and pc_i=0x4 in cycle 1 -> cycle 0 after release: instr_ID=0x13, valid_ID=0, pc_ID=0. Cycle 1: instr_ID=0x00500093, valid_ID=1.
- 1-cycle stall with ID=(pc 0x8, 0x00208133), instr_i changing to 0xDEADBEEF -> next cycle still pc_ID=0x8, instr_ID=0x00208133, valid=1.
- 3-cycle stall -> identical pair for 4 cycles; then resumes with the new instr_i.
- flush pulse, FLUSH_DEPTH=2 and, in a second build, FLUSH_DEPTH=4 -> exactly 2 / 4 consecutive cycles of 0x13 with valid=0, then normal flow.
- flush and stall in the same cycle -> that cycle and the next show NOP/valid 0; pc_ID is held.
- IF_ID_PERF_EN build: 2 flushes (FLUSH_DEPTH=2) plus 3 stall cycles after reset -> perf_bubble_cnt=5 (4 plus 1 reset bubble), perf_stall_cnt=3. Without the macro, both outputs read 0.
